adder_share_ctrl: RTL and testbench

Shares one instance of the team's 5-cycle pipelined 8-bit adder among NREQ requesters. Each cycle it arbitrates among valid requests, issues at most one operation into the adder, and tracks the requester ID of every in-flight operation through a tag pipeline matched to the adder latency. Results are routed back to the issuing requester with no reordering. It sits between the requester blocks and the adder pipeline; the adder itself is instantiated outside this block.

---
 rtl/adder_share_pkg.sv | 25 ++
 rtl/adder_share_ctrl_rr_arbiter.sv | 61 ++++++
 rtl/adder_share_ctrl.sv | 119 +++++++++++
 tb/tb_adder_share_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_share_pkg: shared constants and tag type for adder_share_ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_share_pkg;

  // Stage count of the shared adder; the controller's default latency tracks it.
  localparam int ADDER_STAGES = 5;
  localparam int LAT_DEF      = ADDER_STAGES;
  localparam int NREQ_MAX     = 8;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int ID_W = id_width(NREQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/adder_share_ctrl_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: N-way one-hot arbiter, round-robin by default, fixed     |
// | priority when ADDER_SHARE_FIXED_PRIO_EN is defined.  Rev 1.0         |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  logic w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i]) begin
        gnt[i]  = 1'b1;
        w_found = 1'b1;
      end
    end
  end
`else
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic          w_found;

  // Search starts at the pointer; offset k is checked before k+1.
  always_comb begin
    gnt     = '0;
    w_next  = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && req[i] && (((int'(r_ptr) + k) % N) == i)) begin
          gnt[i]  = 1'b1;
          w_next  = PW'((i + 1) % N);
          w_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_share_ctrl: shares one pipelined adder among NREQ requesters.  |
// | Option macro: ADDER_SHARE_FIXED_PRIO_EN.  Rev 1.0                    |
// +----------------------------------------------------------------------+
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int LAT     = LAT_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_ina,
  output logic [WIDTH-1:0]      add_inb,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  localparam int               CNT_W     = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] r_cnt [NREQ];
  tag_t             r_tag [LAT];
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic [NREQ-1:0]  w_rsp;
  logic [ID_W-1:0]  w_gid;
  logic             w_any;

  // Gating with rst keeps grants, responses and busy at 0 during reset.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign w_elig[i] = !rst && req_valid[i] && (r_cnt[i] < C_MAX_OUT);
    assign w_rsp[i]  = !rst && r_tag[LAT-1].valid && (r_tag[LAT-1].id == ID_W'(i));
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_elig),
    .gnt (w_gnt)
  );

  assign req_ready = w_gnt;
  assign rsp_valid = w_rsp;
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;

  always_comb begin
    add_ina = '0;
    add_inb = '0;
    add_cin = 1'b0;
    w_gid   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        add_ina = req_a[i*WIDTH +: WIDTH];
        add_inb = req_b[i*WIDTH +: WIDTH];
        add_cin = req_cin[i];
        w_gid   = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      w_any = w_any | r_tag[s].valid;
    end
  end

  assign busy = w_any && !rst;

  // The adder is free-running, so the tag pipeline never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag[s].valid <= 1'b0;
      end
    end else begin
      r_tag[0].valid <= |w_gnt;
      r_tag[0].id    <= w_gid;
      for (int s = 1; s < LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && !w_rsp[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_gnt[i] && w_rsp[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder_share_ctrl: scoreboard bench with a behavioural 5-stage     |
// | adder.  Rev 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_adder_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int L  = 5;
  localparam int MO = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [W-1:0]   add_ina;
  logic [W-1:0]   add_inb;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  typedef struct {
    int         id;
    logic [8:0] res;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   o_cnt [N];

  always #5 clk = ~clk;

  adder_share_ctrl #(
    .NREQ    (N),
    .WIDTH   (W),
    .LAT     (L),
    .MAX_OUT (MO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_ina   (add_ina),
    .add_inb   (add_inb),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  // Behavioural adder: operands captured at the edge, sum visible L cycles later.
  logic [8:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_ina} + {1'b0, add_inb} + {8'b0, add_cin};
    for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
  end
  assign add_sum  = pipe[L-1][7:0];
  assign add_cout = pipe[L-1][8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, ex, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
    req_valid[i]       = v;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_cin[i]         = c;
  endtask

  // mode 0: no directed ready check; 1: ready must equal er;
  // 2: fixed-priority expectation from the outstanding counts of req0/req2.
  task automatic tick(input int mode, input logic [N-1:0] er);
    logic [N-1:0] ev;
    logic [8:0]   eres;
    logic [N-1:0] erdy;
    logic [7:0]   a, b;
    #1;
    if (rst) q.delete();
    for (int i = 0; i < N; i++) o_cnt[i] = 0;
    foreach (q[j]) o_cnt[q[j].id]++;
    ev   = '0;
    eres = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev   = N'(1 << q[0].id);
      eres = q[0].res;
    end
    chk("busy", {31'b0, busy}, {31'b0, (q.size() > 0) && !rst});
    if (ev != '0) void'(q.pop_front());
    chk("rsp_valid", {28'b0, rsp_valid}, {28'b0, ev});
    if (ev != '0) chk("rsp_result", {23'b0, rsp_cout, rsp_sum}, {23'b0, eres});
    if (mode == 1) chk("ready_dir", {28'b0, req_ready}, {28'b0, er});
    if (mode == 2) begin
      erdy = (o_cnt[0] < MO) ? 4'b0001 : (o_cnt[2] < MO) ? 4'b0100 : 4'b0000;
      chk("ready_fixed", {28'b0, req_ready}, {28'b0, erdy});
    end
    chk("ready_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
    chk("ready_needs_valid", {28'b0, req_ready & ~req_valid}, 32'd0);
    if (req_ready == '0) chk("issue_idle", {15'b0, add_cin, add_ina, add_inb}, 32'd0);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        a = req_a[i*W +: W];
        b = req_b[i*W +: W];
        chk("issue_ops", {15'b0, add_cin, add_ina, add_inb}, {15'b0, req_cin[i], a, b});
        if (req_valid[i])
          q.push_back('{id: i, res: {1'b0, a} + {1'b0, b} + {8'b0, req_cin[i]}, due: cyc + L});
      end
    end
    chk("cnt0_bound", {31'b0, dut.r_cnt[0] <= 2'(MO)}, 32'd1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    @(posedge clk);
    #1;
    tick(1, 4'b0000);
    tick(1, 4'b0000);
    rst = 1'b0;
    tick(1, 4'b0000);

    // Single op from requester 0: 0xFF + 0x01 + 1 = 0x101
    set_req(0, 1'b1, 8'hFF, 8'h01, 1'b1);
    tick(1, 4'b0001);
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (8) tick(1, 4'b0000);

`ifndef ADDER_SHARE_FIXED_PRIO_EN
    // Contention; pointer sits at 1 after the single op to requester 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(i), 8'h10, 1'b0);
    for (int k = 0; k < 12; k++) tick(1, 4'(1 << ((k + 1) % 4)));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (8) tick(1, 4'b0000);
`else
    set_req(0, 1'b1, 8'h21, 8'h05, 1'b0);
    set_req(2, 1'b1, 8'h7F, 8'h80, 1'b1);
    for (int k = 0; k < 16; k++) tick(2, 4'b0000);
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (8) tick(1, 4'b0000);
`endif

    // Outstanding limit on requester 0, including grant+response at k=6.
    set_req(0, 1'b1, 8'h33, 8'h44, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) chk("cnt_at_limit", {30'b0, dut.r_cnt[0]}, 32'd2);
      if (k == 6) chk("cnt_after_rsp", {30'b0, dut.r_cnt[0]}, 32'd1);
      if (k == 7) chk("cnt_grant_and_rsp", {30'b0, dut.r_cnt[0]}, 32'd1);
      if (k == 8) chk("cnt_refill", {30'b0, dut.r_cnt[0]}, 32'd2);
      tick(1, (k == 0 || k == 1 || k == 6 || k == 7) ? 4'b0001 : 4'b0000);
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (8) tick(1, 4'b0000);

    // Reset while three ops are in flight: none of them may respond.
    set_req(1, 1'b1, 8'h01, 8'h02, 1'b0);
    tick(1, 4'b0010);
    set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h03, 8'h04, 1'b1);
    tick(1, 4'b0100);
    set_req(2, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(3, 1'b1, 8'h05, 8'h06, 1'b0);
    tick(1, 4'b1000);
    set_req(3, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick(1, 4'b0000);
    rst = 1'b0;
    repeat (10) tick(1, 4'b0000);

    // Recovery after reset.
    set_req(2, 1'b1, 8'h80, 8'h80, 1'b0);
    tick(1, 4'b0100);
    set_req(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (8) tick(1, 4'b0000);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
